// File: rtl/bus_arbiter_pkg.sv
// Shared types for the I/D line-fill arbiter: FSM states, owner encoding, line geometry.
// System-bus tag field codes sit here too so every user sees one definition.
`ifndef SYSBUS_DEFS_SV
`define SYSBUS_DEFS_SV
`define SYSBUS_READ   1'b1
`define SYSBUS_WRITE  1'b0
`define SYSBUS_MEMORY 4'b0001
`define SYSBUS_MMIO   4'b0011
`endif

package bus_arbiter_pkg;

  localparam int LINE_BEATS  = 8;
  localparam int ADDR_WIDTH  = 64;
  localparam int LINE_OFFSET = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_RESPOND = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // Two-way round-robin: a lone requester wins, a tie goes to whoever was not granted last.
  function automatic owner_t rr_pick(input logic i_vld, input logic d_vld, input owner_t last);
    if (i_vld && d_vld) begin
      return (last == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
    end
    return d_vld ? OWN_DATA : OWN_INSTR;
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Arbitrates instruction and data line fills onto one system bus and routes the
// returning beats back to the latched owner; one transaction in flight at a time.
module bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_req_valid,
  input  logic [63:0]               i_req_addr,
  input  logic                      d_req_valid,
  input  logic [63:0]               d_req_addr,
  output logic                      i_grant,
  output logic                      d_grant,
  output logic                      i_resp_valid,
  output logic                      d_resp_valid,
  output logic [BUS_DATA_WIDTH-1:0] resp_data,
  output logic                      i_resp_last,
  output logic                      d_resp_last,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  import bus_arbiter_pkg::*;

  localparam int CNT_W  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int LINE_W = ADDR_WIDTH - LINE_OFFSET;

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_q, last_d;
  logic [LINE_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic   grant_vld;
  owner_t grant_own;
  logic   beat;
  logic   last_beat;
  logic   in_request;

  // Low address bits are dropped by line alignment; routing never looks at the response tag.
  logic unused_bits;
  assign unused_bits = ^{i_req_addr[LINE_OFFSET-1:0], d_req_addr[LINE_OFFSET-1:0], bus_resptag};

  always_comb begin
    grant_vld  = !reset && (state_q == ST_IDLE) && (i_req_valid || d_req_valid);
    grant_own  = rr_pick(i_req_valid, d_req_valid, last_q);
    in_request = !reset && (state_q == ST_REQUEST);
    beat       = !reset && (state_q == ST_RESPOND) && bus_respcyc;
    last_beat  = beat && (cnt_q == CNT_W'(LINE_BEATS - 1));
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          owner_d = grant_own;
          last_d  = grant_own;
          addr_d  = (grant_own == OWN_DATA) ? d_req_addr[ADDR_WIDTH-1:LINE_OFFSET]
                                            : i_req_addr[ADDR_WIDTH-1:LINE_OFFSET];
          cnt_d   = '0;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (bus_reqack) begin
          cnt_d   = '0;
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (beat) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_INSTR;
      last_q  <= OWN_DATA;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant and beat forwarding are same-cycle so a fill never pays an extra bubble.
  always_comb begin
    i_grant      = grant_vld && (grant_own == OWN_INSTR);
    d_grant      = grant_vld && (grant_own == OWN_DATA);
    bus_reqcyc   = in_request;
    bus_req      = in_request ? BUS_DATA_WIDTH'({addr_q, {LINE_OFFSET{1'b0}}}) : '0;
    bus_reqtag   = in_request ? BUS_TAG_WIDTH'({`SYSBUS_READ, `SYSBUS_MEMORY, 8'(owner_q)}) : '0;
    bus_respack  = beat;
    resp_data    = beat ? bus_resp : '0;
    i_resp_valid = beat && (owner_q == OWN_INSTR);
    d_resp_valid = beat && (owner_q == OWN_DATA);
    i_resp_last  = last_beat && (owner_q == OWN_INSTR);
    d_resp_last  = last_beat && (owner_q == OWN_DATA);
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: the bus model pushes each beat it drives, the
// per-cycle sampler collects forwarded beats, and each test compares the two queues.
module tb_bus_arbiter;

  typedef struct packed {
    logic        own;
    logic [63:0] dat;
    logic        last;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        i_req_valid, d_req_valid;
  logic [63:0] i_req_addr, d_req_addr;
  logic        i_grant, d_grant;
  logic        i_resp_valid, d_resp_valid;
  logic [63:0] resp_data;
  logic        i_resp_last, d_resp_last;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    n_cmp, n_bad;
  int    g_i, g_d, both_g, both_v, ack_err;
  int    rq_cycles, rq_bad;
  logic  in_resp;

  bus_arbiter #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .LINE_BEATS(8)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_resp_valid(i_resp_valid), .d_resp_valid(d_resp_valid),
    .resp_data(resp_data),
    .i_resp_last(i_resp_last), .d_resp_last(d_resp_last),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Samples the current cycle away from the edge, then moves to 1ns after the next edge.
  task automatic tick();
    #1;
    if (i_grant === 1'b1) g_i++;
    if (d_grant === 1'b1) g_d++;
    if (i_grant === 1'b1 && d_grant === 1'b1) both_g++;
    if (i_resp_valid === 1'b1 && d_resp_valid === 1'b1) both_v++;
    if (i_resp_valid === 1'b1 || d_resp_valid === 1'b1)
      obs_q.push_back('{d_resp_valid, resp_data, d_resp_valid ? d_resp_last : i_resp_last});
    if (bus_respack !== (bus_respcyc && in_resp && !reset)) ack_err++;
    @(posedge clk);
    #1;
  endtask

  // Bus-side model for one granted fill, entered in the first REQUEST cycle.
  task automatic serve(input logic own, input logic [63:0] exp_req, input logic [12:0] exp_tag,
                       input int ack_dly, input int max_gap);
    int gap;
    rq_cycles = 0;
    rq_bad    = 0;
    for (int c = 0; c <= ack_dly; c++) begin
      bus_reqack = (c == ack_dly);
      #1;
      if (bus_reqcyc === 1'b1) rq_cycles++;
      if (bus_req !== exp_req || bus_reqtag !== exp_tag) rq_bad++;
      tick();
    end
    bus_reqack = 1'b0;
    in_resp    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) tick();
      bus_respcyc = 1'b1;
      bus_resp    = {$urandom, $urandom};
      bus_resptag = 13'(~{12'd0, own});
      exp_q.push_back('{own, bus_resp, (k == 7)});
      tick();
      bus_respcyc = 1'b0;
      bus_resp    = '0;
    end
    in_resp = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_req_valid = 1'b1; d_req_valid = 1'b1;
    i_req_addr = 64'h1234; d_req_addr = 64'h5678;
    bus_respcyc = 1'b1; bus_resp = 64'hFFFF_FFFF_FFFF_FFFF; bus_reqack = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    n_cmp++; if ({i_grant, d_grant} !== 2'b00) begin n_bad++; $display("FAIL reset_grants got %b want 00", {i_grant, d_grant}); end
    n_cmp++; if ({bus_reqcyc, bus_respack} !== 2'b00) begin n_bad++; $display("FAIL reset_bus_strobes got %b want 00", {bus_reqcyc, bus_respack}); end
    n_cmp++; if ({i_resp_valid, d_resp_valid, i_resp_last, d_resp_last} !== 4'b0000) begin n_bad++; $display("FAIL reset_resp_flags got %b want 0000", {i_resp_valid, d_resp_valid, i_resp_last, d_resp_last}); end
    n_cmp++; if (bus_req !== 64'd0 || bus_reqtag !== 13'd0) begin n_bad++; $display("FAIL reset_req_fields got %h/%h want 0/0", bus_req, bus_reqtag); end
    n_cmp++; if (resp_data !== 64'd0) begin n_bad++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
    bus_respcyc = 1'b0; bus_resp = '0; bus_reqack = 1'b0;
  endtask

  task automatic test_tie_after_reset();
    beat_t e, o;
    g_i = 0; g_d = 0;
    i_req_addr = 64'h0000_0000_0000_107F;
    d_req_addr = 64'h8000_0000_0000_0FFF;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++; if ({i_grant, d_grant} !== 2'b10) begin n_bad++; $display("FAIL tie_first_grant got %b want 10", {i_grant, d_grant}); end
    tick();
    i_req_valid = 1'b0; i_req_addr = 64'hDEAD;
    serve(1'b0, 64'h1040, 13'h1100, 0, 0);
    n_cmp++; if (g_d !== 0) begin n_bad++; $display("FAIL tie_early_d_grant got %0d want 0", g_d); end
    #1;
    n_cmp++; if ({i_grant, d_grant} !== 2'b01) begin n_bad++; $display("FAIL tie_second_grant got %b want 01", {i_grant, d_grant}); end
    tick();
    d_req_valid = 1'b0; d_req_addr = 64'hBEEF;
    serve(1'b1, 64'h8000_0000_0000_0FC0, 13'h1101, 0, 0);
    n_cmp++; if (exp_q.size() != obs_q.size()) begin n_bad++; $display("FAIL tie_beat_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL tie_beat got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_single_instr();
    beat_t e, o;
    i_req_valid = 1'b1; i_req_addr = 64'h1234;
    #1;
    n_cmp++; if ({i_grant, d_grant} !== 2'b10) begin n_bad++; $display("FAIL single_grant got %b want 10", {i_grant, d_grant}); end
    tick();
    i_req_valid = 1'b0; i_req_addr = 64'h0;
    #1;
    n_cmp++; if (bus_reqcyc !== 1'b1 || bus_req !== 64'h1200 || bus_reqtag !== 13'h1100) begin n_bad++; $display("FAIL single_request got %b/%h/%h want 1/1200/1100", bus_reqcyc, bus_req, bus_reqtag); end
    serve(1'b0, 64'h1200, 13'h1100, 0, 0);
    n_cmp++; if (exp_q.size() != obs_q.size()) begin n_bad++; $display("FAIL single_beat_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL single_beat got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_ack_delay();
    beat_t e, o;
    d_req_valid = 1'b1; d_req_addr = 64'hFFFF_0000_0000_00C7;
    #1;
    n_cmp++; if ({i_grant, d_grant} !== 2'b01) begin n_bad++; $display("FAIL delay_grant got %b want 01", {i_grant, d_grant}); end
    tick();
    d_req_valid = 1'b0; d_req_addr = 64'h0;
    serve(1'b1, 64'hFFFF_0000_0000_00C0, 13'h1101, 5, 0);
    n_cmp++; if (rq_cycles !== 6) begin n_bad++; $display("FAIL delay_reqcyc_cycles got %0d want 6", rq_cycles); end
    n_cmp++; if (rq_bad !== 0) begin n_bad++; $display("FAIL delay_req_unstable got %0d want 0", rq_bad); end
    n_cmp++; if (exp_q.size() != obs_q.size()) begin n_bad++; $display("FAIL delay_beat_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL delay_beat got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Last grant went to data, so the tie must go to instruction; both fills use beat gaps.
  task automatic test_gaps_round_robin();
    beat_t e, o;
    ack_err = 0;
    i_req_valid = 1'b1; i_req_addr = 64'h0000_0000_0ABC_DE40;
    d_req_valid = 1'b1; d_req_addr = 64'h0000_0000_0000_0001;
    #1;
    n_cmp++; if ({i_grant, d_grant} !== 2'b10) begin n_bad++; $display("FAIL rr_tie_grant got %b want 10", {i_grant, d_grant}); end
    tick();
    i_req_valid = 1'b0;
    serve(1'b0, 64'h0000_0000_0ABC_DE40, 13'h1100, 2, 3);
    #1;
    n_cmp++; if ({i_grant, d_grant} !== 2'b01) begin n_bad++; $display("FAIL rr_second_grant got %b want 01", {i_grant, d_grant}); end
    tick();
    d_req_valid = 1'b0;
    serve(1'b1, 64'h0, 13'h1101, 1, 3);
    n_cmp++; if (ack_err !== 0) begin n_bad++; $display("FAIL gaps_respack_mirror got %0d bad cycles want 0", ack_err); end
    n_cmp++; if (exp_q.size() != obs_q.size()) begin n_bad++; $display("FAIL gaps_beat_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL gaps_beat got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_fill();
    beat_t e, o;
    ack_err = 0;
    d_req_valid = 1'b1; d_req_addr = 64'h0000_0000_0000_3000;
    tick();
    d_req_valid = 1'b0;
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    in_resp    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus_respcyc = 1'b1; bus_resp = {$urandom, $urandom};
      exp_q.push_back('{1'b1, bus_resp, 1'b0});
      tick();
    end
    bus_respcyc = 1'b1; bus_resp = 64'hA5A5_A5A5_A5A5_A5A5;
    reset = 1'b1; in_resp = 1'b0;
    #1;
    n_cmp++; if ({d_resp_valid, d_resp_last, bus_respack} !== 3'b000) begin n_bad++; $display("FAIL midreset_flags got %b want 000", {d_resp_valid, d_resp_last, bus_respack}); end
    n_cmp++; if (resp_data !== 64'd0) begin n_bad++; $display("FAIL midreset_data got %h want 0", resp_data); end
    tick();
    tick();
    reset = 1'b0;
    repeat (2) tick();
    bus_respcyc = 1'b0; bus_resp = '0;
    n_cmp++; if (ack_err !== 0) begin n_bad++; $display("FAIL midreset_stray_respack got %0d want 0", ack_err); end
    n_cmp++; if (exp_q.size() != obs_q.size()) begin n_bad++; $display("FAIL midreset_beat_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL midreset_beat got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    i_req_valid = 1'b1; i_req_addr = 64'h0000_0000_0000_7788;
    #1;
    n_cmp++; if ({i_grant, d_grant} !== 2'b10) begin n_bad++; $display("FAIL refill_grant got %b want 10", {i_grant, d_grant}); end
    tick();
    i_req_valid = 1'b0;
    serve(1'b0, 64'h0000_0000_0000_7780, 13'h1100, 0, 1);
    n_cmp++; if (exp_q.size() != obs_q.size()) begin n_bad++; $display("FAIL refill_beat_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL refill_beat got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++; if (both_g !== 0 || both_v !== 0) begin n_bad++; $display("FAIL exclusive_outputs got %0d/%0d want 0/0", both_g, both_v); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    g_i = 0; g_d = 0; both_g = 0; both_v = 0; ack_err = 0;
    rq_cycles = 0; rq_bad = 0; in_resp = 1'b0;
    reset = 1'b1; i_req_valid = 1'b0; d_req_valid = 1'b0;
    i_req_addr = '0; d_req_addr = '0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    test_reset();
    test_tie_after_reset();
    test_single_instr();
    test_ack_delay();
    test_gaps_round_robin();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
